// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider family and its measurement monitor.
// Contents:
//   CntWDefault        - default phase/period counter width
//   SyncStagesDefault  - default depth of the div_in synchroniser
//   meas_state_e       - measurement FSM states
package clk_div_pkg;

    localparam int unsigned CntWDefault       = 16;
    localparam int unsigned SyncStagesDefault = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHigh = 2'd1,
        StLow  = 2'd2
    } meas_state_e;

endpackage

// File: rtl/sync_edge.sv
// Resynchronises an asynchronous level into the clk_i domain and flags both edges.
// Ports:
//   clk_i   - sampling clock
//   rst_ni  - asynchronous active-low reset
//   d_i     - asynchronous input level
//   rise_o  - one-cycle pulse, synchronised level went 0 -> 1
//   fall_o  - one-cycle pulse, synchronised level went 1 -> 0
module sync_edge
    import clk_div_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    // Fills with ones after reset release; edges are ignored until the whole
    // pipe (synchroniser plus s_d) holds real samples, so a level that was
    // already high across reset release is not mistaken for a rising edge.
    logic [SYNC_STAGES:0]   warm_q;
    logic                   s;
    logic                   edge_en;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
            warm_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            s_d_q  <= sync_q[SYNC_STAGES-1];
            warm_q <= {warm_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign edge_en = warm_q[SYNC_STAGES];
    assign rise_o  = edge_en &  s & ~s_d_q;
    assign fall_o  = edge_en & ~s &  s_d_q;

endmodule

// File: rtl/clk_div_meas.sv
// Measures the high phase, low phase and period of a divided clock in clk_i cycles.
// Ports:
//   clk_i        - reference clock
//   rst_ni       - asynchronous active-low reset
//   clr_i        - synchronous clear: abort measurement, drop ovf/stable history
//   div_in_i     - divided clock under measurement (may be asynchronous)
//   meas_valid_o - one-cycle strobe, result buses updated on this cycle
//   high_cnt_o   - high-phase length of the last full period
//   low_cnt_o    - low-phase length of the last full period
//   period_o     - high_cnt_o + low_cnt_o
//   stable_o     - last two published periods were identical
//   ovf_o        - sticky, phase counter reached saturation
module clk_div_meas
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W       = CntWDefault,
    parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             div_in_i,
    output logic             meas_valid_o,
    output logic [CNT_W-1:0] high_cnt_o,
    output logic [CNT_W-1:0] low_cnt_o,
    output logic [CNT_W:0]   period_o,
    output logic             stable_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic rise;
    logic fall;
    logic edge_det;

    meas_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic             ovf_q, ovf_d;
    logic             have_prev_q, have_prev_d;
    logic             stable_q, stable_d;
    logic             valid_q;
    logic [CNT_W-1:0] high_q, low_q;
    logic [CNT_W:0]   period_q;

    logic cnt_sat;
    logic ovf_hit;
    logic abort;
    logic capture;
    logic publish;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (div_in_i),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign edge_det = rise | fall;
    assign cnt_sat  = (cnt_q == CntMax);

    // Phase counter: restarts at 1 on every edge, holds at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (edge_det) begin
            cnt_d = CNT_W'(1);
        end else if (!cnt_sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ovf flags the counter arriving at all-ones; the measurement is only
    // abandoned once the phase runs past it, so a phase of exactly all-ones
    // cycles is still published.
    assign ovf_hit = !edge_det && (cnt_d == CntMax);
    assign abort   = !edge_det && cnt_sat;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        publish = 1'b0;
        if (clr_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rise) state_d = StHigh;
                end
                StHigh: begin
                    if (abort) begin
                        state_d = StIdle;
                    end else if (fall) begin
                        capture = 1'b1;
                        state_d = StLow;
                    end
                end
                StLow: begin
                    if (abort) begin
                        state_d = StIdle;
                    end else if (rise) begin
                        publish = 1'b1;
                        state_d = StHigh;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        hi_d        = capture ? cnt_q : hi_q;
        ovf_d       = clr_i ? 1'b0 : (ovf_q | ovf_hit);
        have_prev_d = have_prev_q;
        stable_d    = stable_q;
        if (clr_i || state_q == StIdle) begin
            have_prev_d = 1'b0;
        end else if (publish) begin
            have_prev_d = 1'b1;
        end
        if (clr_i) begin
            stable_d = 1'b0;
        end else if (publish) begin
            stable_d = (hi_q == high_q) && (cnt_q == low_q) && have_prev_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hi_q        <= '0;
            ovf_q       <= 1'b0;
            have_prev_q <= 1'b0;
            stable_q    <= 1'b0;
            valid_q     <= 1'b0;
            high_q      <= '0;
            low_q       <= '0;
            period_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            ovf_q       <= ovf_d;
            have_prev_q <= have_prev_d;
            stable_q    <= stable_d;
            valid_q     <= publish;
            if (publish) begin
                high_q   <= hi_q;
                low_q    <= cnt_q;
                period_q <= {1'b0, hi_q} + {1'b0, cnt_q};
            end
        end
    end

    assign meas_valid_o = valid_q;
    assign high_cnt_o   = high_q;
    assign low_cnt_o    = low_q;
    assign period_o     = period_q;
    assign stable_o     = stable_q;
    assign ovf_o        = ovf_q;

endmodule
